// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame transmitter: state encoding,
// default 12 MHz timing, GRB colours and the pixel-to-frame-bit ordering
// used by the transmitter, the life engine and the bench alike.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } ws_state_e;

  // Timing at 12 MHz: 0.4 us / 0.83 us high, 1.25 us bit, ~83 us latch.
  localparam int DEF_T0H     = 5;
  localparam int DEF_T1H     = 10;
  localparam int DEF_T_BIT   = 15;
  localparam int DEF_T_RESET = 1000;

  // Colours are packed {G,R,B}, which is also the on-wire order.
  localparam logic [23:0] DEF_ALIVE_GRB = 24'h00_10_00;
  localparam logic [23:0] DEF_DEAD_GRB  = 24'h00_00_00;

  // Pixel k is row k/8; the column is reversed on odd rows of a
  // serpentine-wired panel. Cell (r,c) lives at frame bit 63-(r*8+c).
  function automatic logic [5:0] pixel_to_frame_bit(input logic [5:0] pix,
                                                    input logic       serpentine);
    logic [2:0] row;
    logic [2:0] col;
    row = pix[5:3];
    col = pix[2:0];
    if (serpentine && row[0]) begin
      col = 3'd7 - col;
    end else begin
      col = pix[2:0];
    end
    return 6'd63 - {row, col};
  endfunction

endpackage

// File: rtl/ws2812_bit_tx.sv
// Single-bit NRZ encoder: on start, drives dout high for T0H or T1H clocks
// (bit value 0 or 1), then low for the rest of T_BIT. high_end marks the
// last high cycle, bit_done the last cycle of the bit, so a new start can
// be issued on that same edge with no gap.
module ws2812_bit_tx #(
  parameter int T0H   = 5,
  parameter int T1H   = 10,
  parameter int T_BIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic bit_i,
  output logic dout_o,
  output logic high_end_o,
  output logic bit_done_o
);

  localparam int CW = $clog2(T_BIT + 1);
  localparam logic [CW-1:0] T0H_C   = CW'(T0H);
  localparam logic [CW-1:0] T1H_C   = CW'(T1H);
  localparam logic [CW-1:0] T_BIT_C = CW'(T_BIT);

  // cnt_q counts the cycles of the current bit already on the wire (1-based).
  logic          active_q, active_d;
  logic          val_q, val_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic [CW-1:0] hi_len_s;

  assign hi_len_s   = val_q ? T1H_C : T0H_C;
  assign high_end_o = active_q && (cnt_q == hi_len_s);
  assign bit_done_o = active_q && (cnt_q == T_BIT_C);
  assign dout_o     = dout_q;

  // Next-state: start a bit, advance within it, or go quiet after it.
  always_comb begin
    active_d = active_q;
    val_d    = val_q;
    cnt_d    = cnt_q;
    dout_d   = 1'b0;
    if (start_i) begin
      active_d = 1'b1;
      val_d    = bit_i;
      cnt_d    = CW'(1);
      dout_d   = 1'b1;
    end else if (active_q) begin
      if (cnt_q == T_BIT_C) begin
        active_d = 1'b0;
        cnt_d    = {CW{1'b0}};
        dout_d   = 1'b0;
      end else begin
        cnt_d  = cnt_q + CW'(1);
        dout_d = (cnt_q < hi_len_s);
      end
    end else begin
      cnt_d  = {CW{1'b0}};
      dout_d = 1'b0;
    end
  end

  // Bit timer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      val_q    <= 1'b0;
      cnt_q    <= {CW{1'b0}};
      dout_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      val_q    <= val_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_tx.sv
// 8x8 frame to WS2812 serialiser. Snapshots a 64-cell frame on handshake,
// streams 64 pixels x 24 GRB bits through ws2812_bit_tx, holds the line
// low for the latch time and pulses frame_done in the first idle cycle.
module ws2812_frame_tx
  import ws2812_pkg::*;
#(
  parameter int          T0H        = DEF_T0H,
  parameter int          T1H        = DEF_T1H,
  parameter int          T_BIT      = DEF_T_BIT,
  parameter int          T_RESET    = DEF_T_RESET,
  parameter logic [23:0] ALIVE_GRB  = DEF_ALIVE_GRB,
  parameter logic [23:0] DEAD_GRB   = DEF_DEAD_GRB,
  parameter bit          SERPENTINE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  input  logic [63:0] frame_data,
  output logic        ready,
  output logic        busy,
  output logic        frame_done,
  output logic        dout
);

  localparam int CNT_MAX = (T_BIT > T_RESET) ? T_BIT : T_RESET;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] T_RESET_C = CW'(T_RESET);

  ws_state_e     state_q, state_d;
  logic [63:0]   snap_q, snap_d;
  logic [5:0]    pix_q, pix_d;
  logic [4:0]    bit_q, bit_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          last_bit_s;
  logic [5:0]    nxt_pix_s, sel_pix_s;
  logic [4:0]    nxt_bit_s, sel_bit_s;
  logic [63:0]   src_s;
  logic [23:0]   colour_s;
  logic          tx_bit_s;
  logic          start_s;
  logic          high_end_s;
  logic          bit_done_s;

  ws2812_bit_tx #(
    .T0H   (T0H),
    .T1H   (T1H),
    .T_BIT (T_BIT)
  ) u_bit_tx (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_s),
    .bit_i      (tx_bit_s),
    .dout_o     (dout),
    .high_end_o (high_end_s),
    .bit_done_o (bit_done_s)
  );

  // Select the bit to launch next: bit 0 of the incoming frame when idle,
  // otherwise the bit after the current one from the snapshot.
  always_comb begin
    last_bit_s = (pix_q == 6'd63) && (bit_q == 5'd23);
    if (bit_q == 5'd23) begin
      nxt_bit_s = 5'd0;
      nxt_pix_s = pix_q + 6'd1;
    end else begin
      nxt_bit_s = bit_q + 5'd1;
      nxt_pix_s = pix_q;
    end
    if (state_q == IDLE) begin
      src_s     = frame_data;
      sel_pix_s = 6'd0;
      sel_bit_s = 5'd0;
    end else begin
      src_s     = snap_q;
      sel_pix_s = nxt_pix_s;
      sel_bit_s = nxt_bit_s;
    end
    colour_s = src_s[pixel_to_frame_bit(sel_pix_s, SERPENTINE)] ? ALIVE_GRB : DEAD_GRB;
    tx_bit_s = colour_s[5'd23 - sel_bit_s];
  end

  // Frame sequencer: handshake, pixel/bit stepping and latch timer.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    pix_d   = pix_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    start_s = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_valid) begin
          snap_d  = frame_data;
          pix_d   = 6'd0;
          bit_d   = 5'd0;
          start_s = 1'b1;
          state_d = HIGH;
        end else begin
          state_d = IDLE;
        end
      end
      HIGH: begin
        if (high_end_s) begin
          state_d = LOW;
        end else begin
          state_d = HIGH;
        end
      end
      LOW: begin
        if (bit_done_s) begin
          pix_d = nxt_pix_s;
          bit_d = nxt_bit_s;
          if (last_bit_s) begin
            state_d = LATCH;
            cyc_d   = CW'(1);
          end else begin
            start_s = 1'b1;
            state_d = HIGH;
          end
        end else begin
          state_d = LOW;
        end
      end
      LATCH: begin
        if (cyc_q == T_RESET_C) begin
          state_d = IDLE;
          cyc_d   = {CW{1'b0}};
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pix_d   = 6'd0;
        bit_d   = 5'd0;
        cyc_d   = {CW{1'b0}};
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = ~ready_d;
  end

  // Sequencer and output registers; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      snap_q  <= 64'd0;
      pix_q   <= 6'd0;
      bit_q   <= 5'd0;
      cyc_q   <= {CW{1'b0}};
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      pix_q   <= pix_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ws2812_frame_tx.sv
// Bench for ws2812_frame_tx: one default-timing instance plus two fast-timing
// instances (row-major and serpentine). A waveform model derived from the
// frame ordering rules predicts every output on every cycle; a pulse monitor
// backs it with hand-computed pulse counts, positions and latencies.
module tb_ws2812_frame_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        v0, v1;
  logic [63:0] d0, d1;
  logic [2:0]  dout_w, ready_w, busy_w, fd_w;

  always #5 clk = ~clk;

  ws2812_frame_tx u_dflt (
    .clk(clk), .reset(reset), .frame_valid(v0), .frame_data(d0),
    .ready(ready_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]), .dout(dout_w[0]));

  ws2812_frame_tx #(.T0H(1), .T1H(2), .T_BIT(3), .T_RESET(10), .SERPENTINE(1'b0)) u_fast (
    .clk(clk), .reset(reset), .frame_valid(v1), .frame_data(d1),
    .ready(ready_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]), .dout(dout_w[1]));

  ws2812_frame_tx #(.T0H(1), .T1H(2), .T_BIT(3), .T_RESET(10), .SERPENTINE(1'b1)) u_fast_s (
    .clk(clk), .reset(reset), .frame_valid(v1), .frame_data(d1),
    .ready(ready_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]), .dout(dout_w[2]));

  int checks   = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic int t0h_of(input int i);  return (i == 0) ? 5 : 1;     endfunction
  function automatic int t1h_of(input int i);  return (i == 0) ? 10 : 2;    endfunction
  function automatic int tbit_of(input int i); return (i == 0) ? 15 : 3;    endfunction
  function automatic int trst_of(input int i); return (i == 0) ? 1000 : 10; endfunction
  function automatic int frame_len(input int i); return 1536 * tbit_of(i) + trst_of(i); endfunction

  // Line level t cycles into the bit stream of frame s.
  function automatic logic exp_dout(input int i, input logic [63:0] s, input int t);
    int b, p, k, bp, r, c;
    logic [23:0] col;
    logic bv;
    b  = t / tbit_of(i);
    p  = t % tbit_of(i);
    k  = b / 24;
    bp = b % 24;
    r  = k / 8;
    c  = k % 8;
    if ((i == 2) && (r % 2 == 1)) c = 7 - c;
    col = s[63 - (r * 8 + c)] ? 24'h00_10_00 : 24'h00_00_00;
    bv  = col[23 - bp];
    return p < (bv ? t1h_of(i) : t0h_of(i));
  endfunction

  // Model: mt = cycles since accept edge (-1 when idle), ms = accepted frame.
  int          mt [3] = '{-1, -1, -1};
  logic [63:0] ms [3];

  // Model update on each active edge from the bench-driven inputs.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mt[i] <= -1;
      end else if ((mt[i] < 0 || mt[i] == frame_len(i)) && ((i == 0) ? v0 : v1)) begin
        mt[i] <= 0;
        ms[i] <= (i == 0) ? d0 : d1;
      end else if (mt[i] >= 0) begin
        mt[i] <= (mt[i] == frame_len(i)) ? -1 : mt[i] + 1;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        logic e_fd, e_rdy, e_dout;
        e_fd   = (mt[i] == frame_len(i));
        e_rdy  = (mt[i] < 0) || e_fd;
        e_dout = (mt[i] >= 0 && mt[i] < 1536 * tbit_of(i)) ? exp_dout(i, ms[i], mt[i]) : 1'b0;
        chk($sformatf("outs_dut%0d_t%0d", i, mt[i]),
            {60'd0, dout_w[i], ready_w[i], busy_w[i], fd_w[i]},
            {60'd0, e_dout, e_rdy, ~e_rdy, e_fd});
      end
    end
  end

  // Pulse monitor: widths, rise-to-rise spacing, positions of long pulses.
  int cyc = 0;
  int clr_gen = 0;
  int clr_seen [3] = '{-1, -1, -1};
  logic prev [3];
  int run [3], npulse [3], long_n [3], minw [3], maxw [3], last_rise [3], mini [3], maxi [3];
  int long_idx [3][64];

  // Free-running cycle count for pulse spacing.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse bookkeeping on the sampling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (clr_seen[i] != clr_gen) begin
        clr_seen[i]  <= clr_gen;
        prev[i]      <= dout_w[i];
        run[i]       <= dout_w[i] ? 1 : 0;
        npulse[i]    <= 0;
        long_n[i]    <= 0;
        minw[i]      <= 1000000;
        maxw[i]      <= 0;
        mini[i]      <= 1000000;
        maxi[i]      <= 0;
        last_rise[i] <= dout_w[i] ? cyc : -1;
      end else begin
        if (dout_w[i] && !prev[i]) begin
          if (last_rise[i] >= 0) begin
            mini[i] <= (cyc - last_rise[i] < mini[i]) ? cyc - last_rise[i] : mini[i];
            maxi[i] <= (cyc - last_rise[i] > maxi[i]) ? cyc - last_rise[i] : maxi[i];
          end
          last_rise[i] <= cyc;
        end
        if (dout_w[i]) begin
          run[i] <= run[i] + 1;
        end else begin
          run[i] <= 0;
          if (prev[i]) begin
            npulse[i] <= npulse[i] + 1;
            minw[i]   <= (run[i] < minw[i]) ? run[i] : minw[i];
            maxw[i]   <= (run[i] > maxw[i]) ? run[i] : maxw[i];
            if (run[i] == t1h_of(i) && long_n[i] < 64) begin
              long_idx[i][long_n[i]] <= npulse[i];
              long_n[i]              <= long_n[i] + 1;
            end
          end
        end
        prev[i] <= dout_w[i];
      end
    end
  end

  // Offer a frame for one cycle; call right after a falling edge.
  task automatic accept(input int g, input logic [63:0] d);
    clr_gen++;
    if (g == 0) begin v0 = 1'b1; d0 = d; end
    else        begin v1 = 1'b1; d1 = d; end
    @(negedge clk);
    v0 = 1'b0;
    v1 = 1'b0;
  endtask

  // Wait (bounded) for frame_done; el = edges since the accept edge.
  task automatic wait_done(input int i, input int maxc, output int el);
    el = 0;
    while (!fd_w[i] && el < maxc) begin
      @(negedge clk);
      el++;
    end
    if (!fd_w[i]) chk($sformatf("timeout_dut%0d", i), {63'd0, fd_w[i]}, 64'd1);
  endtask

  int          el;
  int          fd_seen;
  logic [63:0] fa, fb;

  initial begin
    reset = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = 64'd0; d1 = 64'd0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", {61'd0, ready_w}, 64'd7);
    chk("rst_busy",  {61'd0, busy_w},  64'd0);
    chk("rst_dout",  {61'd0, dout_w},  64'd0);
    chk("rst_done",  {61'd0, fd_w},    64'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    chk("idle_ready", {61'd0, ready_w}, 64'd7);
    chk("idle_dout",  {61'd0, dout_w},  64'd0);

    // All-dead frame at default timing.
    accept(0, 64'd0);
    wait_done(0, 30000, el);
    chk("latency_dflt", el, 64'd24040);
    chk("npulse_dflt", npulse[0], 64'd1536);
    chk("long_dflt", long_n[0], 64'd0);
    chk("minw_dflt", minw[0], 64'd5);
    chk("maxw_dflt", maxw[0], 64'd5);
    chk("mini_dflt", mini[0], 64'd15);
    chk("maxi_dflt", maxi[0], 64'd15);

    // Only cell (0,0) alive: the one long pulse is R bit 3 of pixel 0.
    @(negedge clk);
    accept(1, 64'h8000_0000_0000_0000);
    wait_done(1, 6000, el);
    chk("latency_fast", el, 64'd4618);
    chk("npulse_fast", npulse[1], 64'd1536);
    chk("long_n_p0", long_n[1], 64'd1);
    chk("long_idx_p0", long_idx[1][0], 64'd11);
    chk("long_idx_p0_s", long_idx[2][0], 64'd11);

    // Only cell (1,0) alive: pixel 8 row-major, pixel 15 serpentine.
    accept(1, 64'h0080_0000_0000_0000);
    wait_done(1, 6000, el);
    chk("long_idx_rowmaj", long_idx[1][0], 64'd203);
    chk("long_idx_serp", long_idx[2][0], 64'd371);

    // Offer while busy is ignored; offer in the frame_done cycle is taken.
    fa = {$urandom, $urandom};
    accept(1, fa);
    repeat (499) @(negedge clk);
    v1 = 1'b1; d1 = ~fa;
    @(negedge clk);
    v1 = 1'b0;
    wait_done(1, 6000, el);
    chk("ignored_long", long_n[1], $countones(fa));
    chk("ignored_long_s", long_n[2], $countones(fa));
    fb = {$urandom, $urandom};
    accept(1, fb);
    chk("b2b_dout", {62'd0, dout_w[2:1]}, 64'd3);
    chk("b2b_ready", {62'd0, ready_w[2:1]}, 64'd0);
    wait_done(1, 6000, el);
    chk("b2b_latency", el, 64'd4618);
    chk("b2b_long", long_n[1], $countones(fb));

    // Reset during pixel 10 (t=720..791), then a clean frame.
    @(negedge clk);
    accept(1, {$urandom, $urandom});
    repeat (735) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_dout",  {61'd0, dout_w},  64'd0);
    chk("midrst_ready", {61'd0, ready_w}, 64'd7);
    chk("midrst_done",  {61'd0, fd_w},    64'd0);
    reset = 1'b0;
    fd_seen = 0;
    repeat (50) begin
      @(negedge clk);
      if (fd_w != 3'd0) fd_seen++;
    end
    chk("midrst_no_done", fd_seen, 64'd0);
    fb = {$urandom, $urandom};
    accept(1, fb);
    wait_done(1, 6000, el);
    chk("post_rst_latency", el, 64'd4618);
    chk("post_rst_long", long_n[1], $countones(fb));
    chk("post_rst_long_s", long_n[2], $countones(fb));

    // A few random frames with a stray offer at a random time.
    for (int n = 0; n < 2; n++) begin
      fa = {$urandom, $urandom};
      accept(1, fa);
      repeat ($urandom_range(4000, 1)) @(negedge clk);
      v1 = 1'b1; d1 = {$urandom, $urandom};
      @(negedge clk);
      v1 = 1'b0;
      wait_done(1, 6000, el);
      chk("rand_long", long_n[1], $countones(fa));
    end

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/ws2812_frame_tx.md
Name: ws2812_frame_tx

Overview:
- Downstream consumer of the 8x8 life engine's 64-bit flattened frame.
- Accepts one frame per handshake, snapshots it, and maps each cell to a 24-bit GRB colour (alive or dead).
- Serialises all 64 pixels onto a single WS2812-style NRZ data line, then holds the latch/reset low time and reports completion.
- Sits between the life engine and the LED-panel data pin; its frame_done pulse is the natural source for the engine's next-frame strobe.

Parameters:
- T0H, 5, clocks dout is high for a 0 bit (0.4 us at 12 MHz)
- T1H, 10, clocks dout is high for a 1 bit
- T_BIT, 15, total clocks per bit; constraint 0 < T0H < T1H < T_BIT
- T_RESET, 1000, clocks of low latch time after the last bit; must be >= 1
- ALIVE_GRB, 24'h00_10_00, colour for a live cell, {G,R,B}
- DEAD_GRB, 24'h00_00_00, colour for a dead cell
- SERPENTINE, 0, 1 = odd rows are emitted in reversed column order

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- frame_valid  input  1  frame_data is offered this cycle
- frame_data  input  64  flattened grid; cell (row r, col c) is bit 63-(r*8+c)
- ready  output  1  block is idle and will accept a frame
- busy  output  1  a frame is being shifted out or latched
- frame_done  output  1  one-cycle pulse when the frame, including latch time, is complete
- dout  output  1  WS2812 serial data

Behaviour:
- Reset: dout=0, ready=1, busy=0, frame_done=0, all counters cleared, state IDLE.
- Reset is synchronous, applies mid-operation, and has priority over everything else.
- Reset mid-frame: dout=0 from the next cycle, no frame_done, and the partial frame is discarded.
- All outputs are registered. busy is always the inverse of ready.
- Handshake:
  - A frame is accepted on a rising edge where frame_valid && ready.
  - frame_data is snapshotted on that edge; later changes to it have no effect.
  - frame_valid while busy is ignored, not queued.
- States:
  - IDLE: ready=1, dout=0.
  - HIGH: dout=1 for T1H clocks if the current bit is 1, otherwise T0H clocks.
  - LOW: dout=0 for the rest of T_BIT.
  - LATCH: dout=0 for T_RESET clocks.
- Transitions:
  - IDLE -> HIGH on accept. dout is 1 in the first cycle after the accept edge.
  - HIGH -> LOW when the high count expires.
  - LOW -> HIGH on the next bit, or LOW -> LATCH after bit 1535.
  - LATCH -> IDLE when T_RESET expires. frame_done=1 and ready=1 in that same first IDLE cycle.
- Back-to-back frames: an accept in the frame_done cycle is legal. The next frame's first high cycle follows immediately.
- Ordering:
  - Pixels k=0..63, with row r=k/8.
  - Column c=k%8, or 7-(k%8) when SERPENTINE=1 and r is odd.
  - Pixel colour is ALIVE_GRB if snapshot bit 63-(r*8+c) is 1, else DEAD_GRB.
  - Within a pixel, bits are sent MSB first: G7..G0, R7..R0, B7..B0.
- Counters:
  - pixel index: 6-bit.
  - bit index: 5-bit, 0..23, wraps to 0 and increments pixel.
  - cycle counter: wide enough for max(T_BIT, T_RESET).
  - No counter may overflow for the legal parameter range.
- Latency: accept edge to frame_done is exactly 1536*T_BIT + T_RESET clocks, i.e. 24040 at defaults.

Decomposition:
- Shared package ws2812_pkg holds:
  - the state enum (IDLE, HIGH, LOW, LATCH);
  - default timing constants for 12 MHz;
  - GRB colour constants;
  - the pixel-index-to-frame-bit mapping function, so the life engine and bench use the same ordering.
- One natural sub-module, ws2812_bit_tx: given a bit and a start strobe, it drives dout high/low for one T_BIT and pulses bit_done.
- ws2812_frame_tx keeps the frame snapshot, pixel/bit sequencing, latch timer and handshake.

Test Plan:
1. Assert reset 3 cycles -> dout=0, ready=1, busy=0, frame_done=0. Hold frame_valid=0 100 cycles -> no change.
2. Defaults, frame_data=0 -> 1536 pulses, each 5 high / 10 low. dout low 1000 cycles, then frame_done exactly 24040 clocks after accept.
3. frame_data=64'h8000_0000_0000_0000 -> pixel 0 bits are 8x'0', then R=0x10 (0,0,0,1,0,0,0,0) with the 4th R bit 10 clocks high, then 8x'0'. Pixels 1..63 are all 0-bits.
4. SERPENTINE=1, frame_data with only bit 55 set (cell 1,0) -> the single 10-clock pulse lands in pixel 15, bit 11. With SERPENTINE=0 it lands in pixel 8.
5. Pulse frame_valid with different data at clock 500 of a frame -> ignored; the transmitted frame is unchanged. Assert frame_valid in the frame_done cycle -> accepted, and dout=1 on the next cycle.
6. Assert reset during pixel 10 -> dout=0 and ready=1 from the next cycle, no frame_done. A new frame then transmits fully and correctly.
